// File: rtl/spi_byte_tx_if.sv
// rtl/spi_byte_tx_if.sv - FIFO read port, enable and SPI pins of spi_byte_tx
interface spi_byte_tx_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic              fifo_e;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              busy;
    logic              frame_done;

    // master: FIFO and host side; slave: the transmitter
    modport master (
        output en, fifo_e, rx_data,
        input  rx_ready, sclk, mosi, cs_n, busy, frame_done
    );

    modport slave (
        input  en, fifo_e, rx_data,
        output rx_ready, sclk, mosi, cs_n, busy, frame_done
    );
endinterface

// File: rtl/spi_byte_tx.sv
// rtl/spi_byte_tx.sv - pops bytes from a FIFO and sends each as one SPI mode-0 frame
module spi_byte_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 1
) (
    input  logic         spi_clk,
    input  logic         rst_n,
    spi_byte_tx_if.slave bus
);
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(CS_IDLE) + 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_e;

    state_e            state_q,   state_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              half_q,    half_d;     // 0: sclk-low half of a bit, 1: sclk-high half

    logic can_fetch;
    logic half_end;
    logic bit_end;
    logic last_bit;
    logic gap_last;

    assign can_fetch = bus.en && !bus.fifo_e;
    assign half_end  = (div_cnt_q == DIV_LAST);
    assign bit_end   = half_end && half_q;
    assign last_bit  = (bit_cnt_q == BIT_LAST);
    assign gap_last  = (gap_cnt_q == GAP_LAST);

    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            half_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            half_q    <= half_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        half_d    = half_q;

        unique case (state_q)
            ST_IDLE: begin
                if (can_fetch) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                shreg_d   = bus.rx_data;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                half_d    = 1'b0;
                state_d   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (half_end) begin
                    div_cnt_d = '0;
                    half_d    = !half_q;
                    if (bit_end) begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            gap_cnt_d = '0;
                            state_d   = ST_GAP;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                // en and fifo_e are only consulted here and in IDLE
                if (gap_last) begin
                    state_d = can_fetch ? ST_FETCH : ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.rx_ready   = (state_q == ST_FETCH);
        bus.busy       = (state_q != ST_IDLE);
        bus.cs_n       = (state_q != ST_SHIFT);
        bus.sclk       = (state_q == ST_SHIFT) && half_q;
        bus.mosi       = (state_q == ST_SHIFT) && shreg_q[DATA_W-1];
        bus.frame_done = (state_q == ST_GAP) && (gap_cnt_q == '0);
    end
endmodule

// File: tb/tb_spi_byte_tx.sv
// tb/tb_spi_byte_tx.sv - scoreboard bench for spi_byte_tx with a FIFO model and SPI receiver model
`timescale 1ns/1ps
module tb_spi_byte_tx;
    localparam int DATA_W    = 8;
    localparam int CLK_DIV   = 2;
    localparam int CS_IDLE   = 1;
    localparam int FRAME_CYC = 2 * DATA_W * CLK_DIV;
    localparam int DONE_LAT  = 2 + FRAME_CYC;
    localparam int PERIOD    = DONE_LAT + CS_IDLE;

    logic spi_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 spi_clk = ~spi_clk;

    spi_byte_tx_if #(.DATA_W(DATA_W)) bus0 ();
    spi_byte_tx_if #(.DATA_W(8))      bus1 ();

    spi_byte_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) u_dut0 (
        .spi_clk (spi_clk),
        .rst_n   (rst_n),
        .bus     (bus0.slave)
    );

    spi_byte_tx #(.DATA_W(8), .CLK_DIV(1), .CS_IDLE(3)) u_dut1 (
        .spi_clk (spi_clk),
        .rst_n   (rst_n),
        .bus     (bus1.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       pop_pend = 1'b0;

    // FIFO model: the pop takes effect just after the edge that ends the FETCH cycle
    always @(negedge spi_clk) pop_pend = rst_n && bus0.rx_ready;
    always @(posedge spi_clk) begin
        #1;
        if (pop_pend) begin
            pop_pend = 1'b0;
            chk("fifo_not_underflowed", fifo_q.size() > 0, 1);
            if (fifo_q.size() > 0) bus0.rx_data = fifo_q.pop_front();
            bus0.fifo_e = (fifo_q.size() == 0);
        end
    end

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        bus0.fifo_e = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge spi_clk);
            #1;
        end
    endtask

    // monitor / SPI receiver model for DUT0
    int         cyc = 0;
    int         n_pop = 0, n_done = 0, n_lost = 0;
    int         t_pop = -1, t_done = -1;
    int         cs_low = 0, rx_bits = 0;
    bit         busy_run = 0, idle_req = 0, load_pend = 0;
    logic       prev_sclk = 0, prev_mosi = 0, prev_cs = 1;
    logic [7:0] rx_sh = '0;

    always @(negedge spi_clk) begin
        cyc++;
        if (!rst_n) begin
            while (n_pop > n_done + n_lost) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_lost++;
            end
            rx_bits = 0; cs_low = 0; t_pop = -1; t_done = -1;
            busy_run = 0; idle_req = 0; load_pend = 0;
            prev_sclk = 0; prev_mosi = 0; prev_cs = 1;
        end else begin
            if (bus0.rx_ready) chk("rx_ready_while_empty", bus0.fifo_e, 0);
            if (bus0.sclk)     chk("mosi_stable_while_sclk_high", bus0.mosi, prev_mosi);
            if (idle_req)      chk("idle_start_latency", bus0.rx_ready, 1);
            if (load_pend) begin
                chk("load_busy", bus0.busy, 1);
                chk("load_cs_n", bus0.cs_n, 1);
            end
            load_pend = bus0.rx_ready;
            if (!bus0.busy) busy_run = 0;
            if (bus0.rx_ready) begin
                if (t_pop >= 0 && busy_run)  chk("fetch_period", cyc - t_pop, PERIOD);
                if (t_done >= 0 && busy_run) chk("frame_done_to_fetch", cyc - t_done, CS_IDLE);
                t_pop = cyc; t_done = -1; busy_run = 1; n_pop++;
            end
            if (!bus0.cs_n) cs_low++;
            if (bus0.sclk && !prev_sclk && !bus0.cs_n) begin
                rx_sh = {rx_sh[6:0], bus0.mosi};
                rx_bits++;
            end
            if (bus0.cs_n && !prev_cs) begin
                chk("frame_done_at_cs_rise", bus0.frame_done, 1);
                chk("cs_low_cycles", cs_low, FRAME_CYC);
                chk("sclk_rising_edges", rx_bits, DATA_W);
                chk("fetch_to_frame_done", cyc - t_pop, DONE_LAT);
                if (exp_q.size() == 0) chk("frame_expected", 0, 1);
                else                   chk("rx_byte", rx_sh, exp_q.pop_front());
                n_done++; cs_low = 0; rx_bits = 0; t_done = cyc;
            end else begin
                chk("frame_done_only_at_cs_rise", bus0.frame_done, 0);
            end
            idle_req  = !bus0.busy && bus0.en && !bus0.fifo_e;
            prev_sclk = bus0.sclk;
            prev_mosi = bus0.mosi;
            prev_cs   = bus0.cs_n;
        end
    end

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((fifo_q.size() != 0 || bus0.busy) && k < budget) begin
            tick(1);
            k++;
        end
        chk("drain_within_budget", k < budget, 1);
    endtask

    task automatic wait_pop(input int base, input int budget);
        int k = 0;
        while (n_pop == base && k < budget) begin
            tick(1);
            k++;
        end
        chk("fetch_within_budget", n_pop != base, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         lost0;
        logic [7:0] b81;

        bus0.en = 1'b0; bus0.fifo_e = 1'b1; bus0.rx_data = '0;
        bus1.en = 1'b0; bus1.fifo_e = 1'b1; bus1.rx_data = 8'h81;
        tick(3);
        chk("rst_cs_n", bus0.cs_n, 1);
        chk("rst_sclk", bus0.sclk, 0);
        chk("rst_mosi", bus0.mosi, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_rx_ready", bus0.rx_ready, 0);
        chk("rst_frame_done", bus0.frame_done, 0);
        rst_n = 1'b1;
        tick(2);

        // single byte
        base = n_pop;
        push(8'hA5);
        tick(1);
        bus0.en = 1'b1;
        wait_drain(200);
        tick(3);
        chk("single_byte_pops", n_pop - base, 1);

        // back-to-back frames
        bus0.en = 1'b0;
        tick(2);
        base = n_pop;
        push(8'h00); push(8'hFF); push(8'h3C);
        tick(1);
        bus0.en = 1'b1;
        wait_drain(400);
        tick(3);
        chk("back_to_back_pops", n_pop - base, 3);

        // empty FIFO with enable high
        base = n_pop;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            chk("empty_busy", bus0.busy, 0);
            chk("empty_cs_n", bus0.cs_n, 1);
        end
        chk("empty_pops", n_pop - base, 0);

        // enable dropped during bit 3
        base = n_pop;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_pop(base, 20);
        tick(14);
        bus0.en = 1'b0;
        tick(150);
        chk("en_drop_pops", n_pop - base, 1);
        chk("en_drop_bytes_left", fifo_q.size(), 3);
        chk("en_drop_busy", bus0.busy, 0);

        // reset during bit 5
        base  = n_pop;
        lost0 = n_lost;
        bus0.en = 1'b1;
        wait_pop(base, 20);
        tick(22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", bus0.cs_n, 1);
        chk("midrst_sclk", bus0.sclk, 0);
        chk("midrst_busy", bus0.busy, 0);
        chk("midrst_mosi", bus0.mosi, 0);
        tick(2);
        rst_n = 1'b1;
        wait_drain(400);
        tick(3);
        chk("midrst_lost_frames", n_lost - lost0, 1);
        chk("midrst_pops", n_pop - base, 3);

        // CLK_DIV=1, CS_IDLE=3 instance
        bus0.en = 1'b0;
        b81 = 8'h81;
        bus1.en = 1'b1; bus1.fifo_e = 1'b0;
        tick(1);
        chk("p_fetch", bus1.rx_ready, 1);
        bus1.fifo_e = 1'b1;
        tick(1);
        chk("p_load_busy", bus1.busy, 1);
        chk("p_load_cs_n", bus1.cs_n, 1);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk("p_cs_n_low", bus1.cs_n, 0);
            chk("p_sclk", bus1.sclk, i % 2);
            chk("p_mosi", bus1.mosi, b81[7 - i / 2]);
        end
        for (int g = 0; g < 3; g++) begin
            tick(1);
            chk("p_gap_cs_n", bus1.cs_n, 1);
            chk("p_gap_sclk", bus1.sclk, 0);
            chk("p_gap_mosi", bus1.mosi, 0);
            chk("p_gap_busy", bus1.busy, 1);
            chk("p_frame_done", bus1.frame_done, g == 0);
        end
        tick(1);
        chk("p_idle_busy", bus1.busy, 0);
        chk("p_no_refetch", bus1.rx_ready, 0);
        bus1.en = 1'b0;

        // random enable / FIFO traffic
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(99) < 4 && fifo_q.size() < 8) push(8'($urandom_range(255)));
            if ($urandom_range(99) < 3) bus0.en = !bus0.en;
            tick(1);
        end
        bus0.en = 1'b1;
        wait_drain(2000);
        tick(5);
        chk("quiesce_done_plus_lost_eq_pops", n_done + n_lost, n_pop);
        chk("quiesce_scoreboard_empty", exp_q.size(), 0);
        chk("quiesce_idle", bus0.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
